// File: rtl/sample_demodulator.sv
// rtl/sample_demodulator.sv - windowed ASK/FSK/BPSK bit recovery with MSB-slice bypass
// Recovers one data bit per SPB valid samples of the 7-bit modulated stream (midline 64).
module sample_demodulator #(
  parameter int SPB            = 16,
  parameter int CARRIER_PERIOD = 4,
  parameter int ASK_THRESH     = 512,
  parameter int FSK_THRESH     = 6,
  parameter int ACC_W          = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] sel,
  input  logic [6:0] sample,
  input  logic       sample_valid,
  input  logic       sync,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       busy
);

  localparam int CNT_W = $clog2(SPB + 1);
  localparam int PH_W  = $clog2(CARRIER_PERIOD);
  localparam int SUM_W = ACC_W + 2;

  typedef enum logic [1:0] {
    MODE_ASK    = 2'b00,
    MODE_FSK    = 2'b01,
    MODE_BPSK   = 2'b10,
    MODE_BYPASS = 2'b11
  } mode_e;

  localparam logic signed [SUM_W-1:0] U_MAX = {2'b00, {ACC_W{1'b1}}};
  localparam logic signed [SUM_W-1:0] S_MAX = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] S_MIN = {3'b111, {(ACC_W-1){1'b0}}};

  mode_e              mode_q, mode_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [CNT_W-1:0]   cross_q, cross_d;
  logic               prev_msb_q, prev_msb_d;
  logic               bit_out_q, bit_out_d;
  logic               bit_valid_q, bit_valid_d;

  logic               win_start;
  mode_e              mode_cur;
  logic [ACC_W-1:0]   acc_base, acc_new;
  logic [CNT_W-1:0]   cnt_new, cross_base, cross_new;
  logic [PH_W-1:0]    phase_base, phase_new;
  logic [6:0]         mag;
  logic signed [7:0]  sdiff;
  logic signed [SUM_W-1:0] term, sum;
  logic               ref_pos, crossed, done, decision;

  always_comb begin
    // sync turns the sample presented alongside it into sample 0 of a fresh window
    win_start  = sync || (cnt_q == '0);
    mode_cur   = win_start ? mode_e'(sel) : mode_q;
    acc_base   = win_start ? '0 : acc_q;
    cross_base = win_start ? '0 : cross_q;
    phase_base = win_start ? '0 : phase_q;
    cnt_new    = (win_start ? '0 : cnt_q) + CNT_W'(1);
    done       = (cnt_new == CNT_W'(SPB));

    mag     = sample[6] ? (sample - 7'd64) : (7'd64 - sample);
    sdiff   = $signed({1'b0, sample}) - 8'sd64;
    ref_pos = (32'(phase_base) < CARRIER_PERIOD / 2);
    crossed = !win_start && (sample[6] != prev_msb_q);

    cross_new = cross_base + {{(CNT_W-1){1'b0}}, crossed};
    phase_new = (32'(phase_base) == CARRIER_PERIOD - 1) ? '0 : phase_base + PH_W'(1);

    term    = '0;
    sum     = '0;
    acc_new = acc_base;
    case (mode_cur)
      MODE_ASK: begin
        term    = $signed({{(SUM_W-7){1'b0}}, mag});
        sum     = $signed({2'b00, acc_base}) + term;
        acc_new = (sum > U_MAX) ? U_MAX[ACC_W-1:0] : sum[ACC_W-1:0];
      end
      MODE_BPSK: begin
        term    = {{(SUM_W-8){sdiff[7]}}, sdiff};
        if (!ref_pos) term = -term;
        sum     = $signed({{2{acc_base[ACC_W-1]}}, acc_base}) + term;
        if (sum > S_MAX)      acc_new = S_MAX[ACC_W-1:0];
        else if (sum < S_MIN) acc_new = S_MIN[ACC_W-1:0];
        else                  acc_new = sum[ACC_W-1:0];
      end
      default: ;
    endcase

    case (mode_cur)
      MODE_ASK:  decision = (32'(acc_new) >= ASK_THRESH);
      MODE_FSK:  decision = (32'(cross_new) >= FSK_THRESH);
      MODE_BPSK: decision = acc_new[ACC_W-1];
      default:   decision = sample[6];
    endcase

    mode_d      = mode_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    cross_d     = cross_q;
    prev_msb_d  = prev_msb_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = 1'b0;

    if (sample_valid) begin
      mode_d = mode_cur;
      if (mode_cur == MODE_BYPASS || done) begin
        bit_out_d   = decision;
        bit_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
        phase_d     = '0;
        cross_d     = '0;
        prev_msb_d  = 1'b0;
      end else begin
        acc_d      = acc_new;
        cnt_d      = cnt_new;
        phase_d    = phase_new;
        cross_d    = cross_new;
        prev_msb_d = sample[6];
      end
    end else if (sync) begin
      acc_d      = '0;
      cnt_d      = '0;
      phase_d    = '0;
      cross_d    = '0;
      prev_msb_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_ASK;
      acc_q       <= '0;
      cnt_q       <= '0;
      phase_q     <= '0;
      cross_q     <= '0;
      prev_msb_q  <= 1'b0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      cross_q     <= cross_d;
      prev_msb_q  <= prev_msb_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign busy      = (cnt_q != '0);

endmodule

// File: tb/tb_sample_demodulator.sv
// tb/tb_sample_demodulator.sv - scoreboard bench for sample_demodulator
module tb_sample_demodulator;

  localparam int SPB = 16;
  localparam int CP  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] sel = 2'b00;
  logic [6:0] sample = '0;
  logic       sample_valid = 1'b0;
  logic       sync = 1'b0;
  logic       bit_out, bit_valid, busy;

  sample_demodulator dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .sample(sample),
    .sample_valid(sample_valid), .sync(sync),
    .bit_out(bit_out), .bit_valid(bit_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int b; int cyc; } exp_t;
  exp_t exp_q[$];
  int   pat[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int model(input int m);
    int acc = 0;
    int cr = 0;
    for (int i = 0; i < pat.size(); i++) begin
      case (m)
        0: acc += (pat[i] >= 64) ? pat[i] - 64 : 64 - pat[i];
        1: if (i > 0 && ((pat[i] >= 64) != (pat[i-1] >= 64))) cr++;
        default: acc += ((i % CP) < CP / 2) ? pat[i] - 64 : 64 - pat[i];
      endcase
    end
    if (m == 0) return (acc >= 512) ? 1 : 0;
    if (m == 1) return (cr >= 6) ? 1 : 0;
    return (acc < 0) ? 1 : 0;
  endfunction

  task automatic send(input int s, input logic sy = 1'b0);
    @(posedge clk); #1;
    sample = 7'(s);
    sample_valid = 1'b1;
    sync = sy;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      sample_valid = 1'b0;
      sync = 1'b0;
    end
  endtask

  task automatic push(input int b);
    exp_t e;
    e.b = b;
    e.cyc = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic run_win(input int m);
    sel = 2'(m);
    foreach (pat[i]) send(pat[i]);
    push(model(m));
    idle(2);
  endtask

  task automatic mk_const(input int v);
    pat = {};
    for (int i = 0; i < SPB; i++) pat.push_back(v);
  endtask

  task automatic mk_period(input int a, input int b, input int half);
    pat = {};
    for (int i = 0; i < SPB; i++) pat.push_back(((i / half) % 2 == 0) ? a : b);
  endtask

  always @(negedge clk) begin
    if (rst_n && bit_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("bit_out", int'(bit_out), e.b);
        check("strobe_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_bit_out", int'(bit_out), 0);
    check("rst_bit_valid", int'(bit_valid), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    idle(2);

    mk_const(64);           run_win(0);
    mk_period(0, 127, 1);   run_win(0);
    mk_period(127, 0, 2);   run_win(1);
    mk_period(127, 0, 8);   run_win(1);
    mk_period(127, 0, 2);   run_win(2);
    mk_period(0, 127, 2);   run_win(2);

    // bypass: back-to-back samples, then a gap
    sel = 2'b11;
    send(100); push(1);
    send(10);  push(0);
    send(127); push(1);
    idle(1);
    check("bypass_busy", int'(busy), 0);
    idle(3);
    send(20);  push(0);
    idle(3);

    // sync after sample 9 aborts the window
    sel = 2'b00;
    mk_period(0, 127, 1);
    for (int i = 0; i < 9; i++) send(pat[i]);
    @(posedge clk); #1;
    sample_valid = 1'b0;
    sync = 1'b1;
    foreach (pat[i]) send(pat[i]);
    push(model(0));
    idle(3);

    // sync on the 16th sample: that sample starts a new window
    for (int i = 0; i < SPB - 1; i++) send(64);
    pat = {};
    pat.push_back(127);
    for (int i = 1; i < SPB; i++) pat.push_back((i % 2) ? 0 : 127);
    send(pat[0], 1'b1);
    for (int i = 1; i < SPB; i++) send(pat[i]);
    push(model(0));
    idle(3);

    // sel change mid-window only takes effect next window
    mk_const(127);
    sel = 2'b00;
    for (int i = 0; i < 5; i++) send(pat[i]);
    sel = 2'b01;
    for (int i = 5; i < SPB; i++) send(pat[i]);
    push(model(0));
    idle(2);
    run_win(1);

    // long valid gap mid-window
    sel = 2'b00;
    mk_period(0, 127, 1);
    for (int i = 0; i < 8; i++) send(pat[i]);
    idle(20);
    check("gap_busy", int'(busy), 1);
    for (int i = 8; i < SPB; i++) send(pat[i]);
    push(model(0));
    idle(3);

    // asynchronous reset mid-window
    check("pre_rst_bit_out", int'(bit_out), 1);
    for (int i = 0; i < 7; i++) send(127);
    idle(1);
    check("pre_rst_busy", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_bit_out", int'(bit_out), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_bit_valid", int'(bit_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mk_period(0, 127, 1);
    run_win(0);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    idle(2);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
